// File: rtl/csa_16bit.sv
// csa_16bit: 16-bit carry-select adder built from 4-bit ripple-carry slices.
// Slice 0 ripples from C_in. Slices 1-3 precompute results for carry-in 0
// and carry-in 1, then pick one using the carry from the slice below.
// The combinational sum feeds arithmetic datapaths directly. A registered
// copy is provided for pipelined consumers.
module csa_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        C_in,
  output logic [15:0] S,
  output logic        C_out,
  output logic [15:0] S_q,
  output logic        C_out_q
);

  // One full adder; returns {cout, s}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic cin);
    logic s;
    logic cout;
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
    return {cout, s};
  endfunction

  // Four full adders rippling a carry; returns {cout, s[3:0]}.
  function automatic logic [4:0] rca4(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin);
    logic [4:0] r;
    logic [1:0] f;
    logic       c;
    r = '0;
    c = cin;
    for (int i = 0; i < 4; i++) begin
      f    = fa(a[i], b[i], c);
      r[i] = f[0];
      c    = f[1];
    end
    r[4] = c;
    return r;
  endfunction

  // Slice 0: a plain ripple from C_in.
  logic [4:0] sl0;
  // Slices 1-3: both carry-in cases are computed in parallel.
  logic [4:0] sl1_c0, sl1_c1, sl1;
  logic [4:0] sl2_c0, sl2_c1, sl2;
  logic [4:0] sl3_c0, sl3_c1, sl3;
  // Carries between slices, named by the bit position they enter.
  logic       c4, c8, c12, c16;

  assign sl0    = rca4(A[3:0], B[3:0], C_in);
  assign c4     = sl0[4];

  assign sl1_c0 = rca4(A[7:4], B[7:4], 1'b0);
  assign sl1_c1 = rca4(A[7:4], B[7:4], 1'b1);
  assign sl1    = c4 ? sl1_c1 : sl1_c0;
  assign c8     = sl1[4];

  assign sl2_c0 = rca4(A[11:8], B[11:8], 1'b0);
  assign sl2_c1 = rca4(A[11:8], B[11:8], 1'b1);
  assign sl2    = c8 ? sl2_c1 : sl2_c0;
  assign c12    = sl2[4];

  assign sl3_c0 = rca4(A[15:12], B[15:12], 1'b0);
  assign sl3_c1 = rca4(A[15:12], B[15:12], 1'b1);
  assign sl3    = c12 ? sl3_c1 : sl3_c0;
  assign c16    = sl3[4];

  assign S      = {sl3[3:0], sl2[3:0], sl1[3:0], sl0[3:0]};
  assign C_out  = c16;

  // Capture the combinational result each clock; reset clears it at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S_q     <= 16'h0000;
      C_out_q <= 1'b0;
    end else begin
      S_q     <= S;
      C_out_q <= C_out;
    end
  end

endmodule

// File: tb/tb_csa_16bit.sv
// tb_csa_16bit: directed and randomized checks of csa_16bit against a
// plain-arithmetic reference of the 17-bit sum A + B + C_in.
module tb_csa_16bit;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        C_in;
  logic [15:0] S;
  logic        C_out;
  logic [15:0] S_q;
  logic        C_out_q;

  int n_chk;
  int n_fail;
  bit rnd_en;

  // Expected registered value, tracked from the adder rule.
  logic [16:0] exp_q;

  csa_16bit dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .C_in    (C_in),
    .S       (S),
    .C_out   (C_out),
    .S_q     (S_q),
    .C_out_q (C_out_q)
  );

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci);
    return {1'b0, a} + {1'b0, b} + {16'h0000, ci};
  endfunction

  task automatic chk(input string nm, input logic [16:0] got, input logic [16:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", nm, got, exp);
    end
  endtask

  // Registered-output model: capture the sum on each edge; reset zeroes it.
  always @(posedge clk or posedge rst) begin
    if (rst) exp_q <= 17'h00000;
    else     exp_q <= model(A, B, C_in);
  end

  // Compare process: every falling edge during the random phase.
  always @(negedge clk) begin
    if (rnd_en) begin
      chk("rnd_comb", {C_out, S}, model(A, B, C_in));
      chk("rnd_reg", {C_out_q, S_q}, exp_q);
    end
  end

  logic [15:0] va [6] = '{16'h0000, 16'h1234, 16'h000F, 16'h0FFF, 16'hFFFF, 16'hFFFF};
  logic [15:0] vb [6] = '{16'h0000, 16'h2345, 16'h0001, 16'h0001, 16'h0001, 16'hFFFF};
  logic [16:0] e0 [6] = '{17'h00000, 17'h03579, 17'h00010, 17'h01000, 17'h10000, 17'h1FFFE};
  logic [16:0] e1 [6] = '{17'h00001, 17'h0357A, 17'h00011, 17'h01001, 17'h10001, 17'h1FFFF};

  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rnd_en = 1'b0;
    clk    = 1'b0;
    rst    = 1'b0;
    A      = 16'h0000;
    B      = 16'h0000;
    C_in   = 1'b0;
    #10;

    // Pin the reference model itself with hand-computed values.
    chk("model_wrap", model(16'hFFFF, 16'h0001, 1'b0), 17'h10000);
    chk("model_max", model(16'hFFFF, 16'hFFFF, 1'b1), 17'h1FFFF);

    // Combinational vectors, no clock activity.
    for (int i = 0; i < 6; i++) begin
      A = va[i]; B = vb[i]; C_in = 1'b0;
      #2;
      chk($sformatf("comb_c0_%0d", i), {C_out, S}, e0[i]);
      C_in = 1'b1;
      #2;
      chk($sformatf("comb_c1_%0d", i), {C_out, S}, e1[i]);
    end

    // Load a nonzero value so reset has something to clear.
    A = 16'h1234; B = 16'h2345; C_in = 1'b0;
    tick();
    chk("reg_load", {C_out_q, S_q}, 17'h03579);
    #2 rst = 1'b1;
    #1;
    chk("reg_async_rst", {C_out_q, S_q}, 17'h00000);
    #2 rst = 1'b0;
    A = 16'hFFFF; B = 16'h0001; C_in = 1'b0;
    #1;
    chk("reg_hold_after_rst", {C_out_q, S_q}, 17'h00000);
    tick();
    chk("reg_wrap", {C_out_q, S_q}, 17'h10000);
    A = 16'h1234; B = 16'h2345; C_in = 1'b1;
    #2;
    chk("reg_no_edge", {C_out_q, S_q}, 17'h10000);
    chk("comb_before_edge", {C_out, S}, 17'h0357A);
    tick();
    chk("reg_after_edge", {C_out_q, S_q}, 17'h0357A);
    #2 rst = 1'b1;
    #1;
    chk("reg_mid_rst", {C_out_q, S_q}, 17'h00000);
    chk("comb_during_rst", {C_out, S}, 17'h0357A);
    #2 rst = 1'b0;
    #5;

    // Randomized phase: inputs change 2 time units after each rising edge.
    rnd_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      clk = 1'b1;
      #2;
      case ($urandom_range(0, 7))
        0: A = 16'hFFFF;
        1: A = 16'h0000;
        default: A = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: B = 16'hFFFF;
        1: B = 16'h0001;
        default: B = 16'($urandom);
      endcase
      C_in = 1'($urandom);
      rst  = ($urandom_range(0, 19) == 0);
      #3 clk = 1'b0;
      #5;
    end
    rnd_en = 1'b0;
    rst    = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_16bit.md
# csa_16bit

16-bit carry-select adder computing S = A + B + C_in with carry out, built from 4-bit ripple-carry blocks whose upper blocks precompute both carry-in cases and select by the incoming block carry. The sum path is purely combinational for use inside arithmetic datapaths. A registered copy of the result is provided for pipelined consumers on the single system clock.

## Interface

- No parameters; width fixed at 16 bits, block size fixed at 4 bits.
- One clock; reset is asynchronous and active-high.
- clk  input  1  system clock; only the registered outputs use it.
- rst  input  1  asynchronous, active-high reset; clears the registered outputs only.
- A  input  16  addend, unsigned.
- B  input  16  addend, unsigned.
- C_in  input  1  carry in to bit 0.
- S  output  16  combinational sum bits [15:0] of A + B + C_in.
- C_out  output  1  combinational carry out of bit 15, i.e. bit 16 of the 17-bit total.
- S_q  output  16  S captured on the rising edge of clk.
- C_out_q  output  1  C_out captured on the rising edge of clk.

## Operation

- Arithmetic: {C_out, S} = A + B + C_in, exact 17-bit unsigned result; no overflow flag, no saturation; wrap-around is carried entirely by C_out.
- Block structure: four 4-bit slices, bits [3:0], [7:4], [11:8], [15:12].
- Slice 0: single 4-bit ripple-carry adder of full adders, carry in = C_in, produces S[3:0] and c4.
- Slices 1-3: two 4-bit ripple-carry adders each, one with carry in 0, one with carry in 1; a 2:1 mux per slice selects sum bits and carry out using the previous slice carry (c4, c8, c12).
- C_out = selected carry out of slice 3 (c16).
- Full adder: s = a ^ b ^ cin; cout = (a & b) | (cin & (a ^ b)).
- No X-propagation special handling; with all inputs known, S and C_out are always known (testbenches compare with case equality).
- Registered outputs: on each rising edge of clk with rst low, S_q <= S and C_out_q <= C_out.

## Timing

- S, C_out: zero-cycle latency, combinational from A, B, C_in; they settle after one ripple through slice 0 plus three mux stages. They do not depend on clk or rst.
- S_q, C_out_q: one-cycle latency; value reflects inputs sampled at the preceding rising clk edge.
- Reset: rst high forces S_q = 16'h0000 and C_out_q = 0 immediately, independent of clk; held while rst is high. Reset mid-operation discards the registered result; the combinational outputs keep tracking the inputs throughout.
- First rising edge after rst deasserts loads the current combinational result.
- No handshake; inputs are expected stable around the clk edge for S_q/C_out_q capture.

## Test plan

- C_in=0: A=0000, B=0000 -> S=0000, C_out=0; A=1234, B=2345 -> S=3579, C_out=0.
- Slice-boundary carry propagation, C_in=0: A=000F, B=0001 -> S=0010, C_out=0; A=0FFF, B=0001 -> S=1000, C_out=0.
- Wrap-around: A=FFFF, B=0001, C_in=0 -> S=0000, C_out=1; A=FFFF, B=FFFF, C_in=0 -> S=FFFE, C_out=1.
- Same six vectors with C_in=1 -> 0001/0, 357A/0, 0011/0, 1001/0, 0001/1, FFFF/1; check after a settle delay with no clock toggling.
- Registered path: assert rst -> S_q=0000, C_out_q=0 without a clock edge; release rst, apply A=FFFF, B=0001, C_in=0, one rising edge -> S_q=0000, C_out_q=1; apply A=1234, B=2345, C_in=1 -> S_q unchanged until the next edge, then 357A/0.
- Reset mid-operation: with S_q=357A, assert rst between edges -> S_q=0000, C_out_q=0 immediately while S still shows 357A.
